// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle.
// The raw button level goes in and the conditioned level, edge pulses and
// busy flag come back out. The master side (board/testbench) drives I; the
// slave side (the debouncer) drives everything else.
`timescale 1ns/1ps
interface btn_debounce_if;
   logic I;
   logic O;
   logic RISE;
   logic FALL;
   logic BUSY;

   modport master (
      output I,
      input  O,
      input  RISE,
      input  FALL,
      input  BUSY
   );

   modport slave (
      input  I,
      output O,
      output RISE,
      output FALL,
      output BUSY
   );
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer.
// The raw button level is synchronised into the fast board clock domain. A new
// level is accepted only after it has been seen for DB_CYCLES consecutive
// cycles. The accepted level drives the downstream counter, and a one-cycle
// RISE or FALL pulse marks each accepted change.
`timescale 1ns/1ps
module btn_debounce #(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic          CLK,
   input  logic          RST,
   btn_debounce_if.slave btn
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   // The final count before a candidate level is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // With a single-cycle window there is nothing to time, so the stable
   // states flip straight across without visiting a WAIT state.
   localparam bit DIRECT = (DB_CYCLES == 1);

   logic             s1_q;
   logic             s_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             o_q, o_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             busy_q, busy_d;

   // Next-state logic. A candidate level is timed in a WAIT state, and any
   // disagreeing sample sends the FSM back to where it came from with the
   // output level untouched. RISE and FALL default low, so each lasts one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      o_d     = o_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            cnt_d = '0;
            if (s_q) begin
               if (DIRECT) begin
                  state_d = STABLE_HI;
                  o_d     = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = WAIT_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         WAIT_HI: begin
            if (!s_q) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               o_d     = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            cnt_d = '0;
            if (!s_q) begin
               if (DIRECT) begin
                  state_d = STABLE_LO;
                  o_d     = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = WAIT_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         WAIT_LO: begin
            if (s_q) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               o_d     = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            o_d     = 1'b0;
         end
      endcase
      busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
   end

   // Synchroniser and FSM registers. Reset clears all state, including the
   // synchroniser, so a button held down through reset is treated as a fresh press.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_q    <= 1'b0;
         s_q     <= 1'b0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         o_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= btn.I;
         s_q     <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         o_q     <= o_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign btn.O    = o_q;
   assign btn.RISE = rise_q;
   assign btn.FALL = fall_q;
   assign btn.BUSY = busy_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed testbench for btn_debounce.
// dutA uses a 4-cycle window and dutB uses a 1-cycle window. Edge numbers
// in the comments count rising edges from the first edge that samples the
// new input level.
`timescale 1ns/1ps
module tb_btn_debounce;

   logic clk;
   logic rst;
   int   passCount;
   int   totalCount;

   btn_debounce_if ifA ();
   btn_debounce_if ifB ();

   btn_debounce #(.DB_CYCLES(4), .CNT_W(3)) dutA (
      .CLK (clk),
      .RST (rst),
      .btn (ifA.slave)
   );

   btn_debounce #(.DB_CYCLES(1), .CNT_W(1)) dutB (
      .CLK (clk),
      .RST (rst),
      .btn (ifB.slave)
   );

   // Free-running 100 MHz clock with rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advances by n rising edges and returns 1 ns after the last one, so
   // outputs are sampled away from the edge.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compares one observed value against the expected value and keeps score.
   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Checks all four dutA outputs at once.
   task automatic checkA(input string tag, input logic o, input logic r, input logic f, input logic b);
      checkOutput({tag, ".O"},    {7'd0, ifA.O},    {7'd0, o});
      checkOutput({tag, ".RISE"}, {7'd0, ifA.RISE}, {7'd0, r});
      checkOutput({tag, ".FALL"}, {7'd0, ifA.FALL}, {7'd0, f});
      checkOutput({tag, ".BUSY"}, {7'd0, ifA.BUSY}, {7'd0, b});
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      rst   = 1'b1;
      ifA.I = 1'b0;
      ifB.I = 1'b0;
      #23;
      $display("[TB] reset state");
      checkA("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(3);
      checkA("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // Clean press: BUSY after edges 2-4, O/RISE after edge 5, RISE clears after edge 6.
      $display("[TB] clean press");
      ifA.I = 1'b1;
      applyStimulus(2);
      checkA("press.e1", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int e = 2; e <= 4; e++) begin
         applyStimulus(1);
         checkA($sformatf("press.e%0d", e), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      applyStimulus(1);
      checkA("press.e5", 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1);
      checkA("press.e6", 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(3);
      checkA("press.hold", 1'b1, 1'b0, 1'b0, 1'b0);

      // Release: FALL for one cycle after edge 5, RISE stays low.
      $display("[TB] release");
      ifA.I = 1'b0;
      applyStimulus(4);
      checkA("release.e3", 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1);
      checkA("release.e4", 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1);
      checkA("release.e5", 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1);
      checkA("release.e6", 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(3);

      // Bounce: I high on edges 0-2, low on edge 3, high from edge 4 onwards.
      // The low sample reaches the FSM at edge 5 and restarts timing, so RISE comes after edge 9.
      $display("[TB] bounce");
      ifA.I = 1'b1;
      applyStimulus(3);
      ifA.I = 1'b0;
      applyStimulus(1);
      ifA.I = 1'b1;
      applyStimulus(1);
      checkA("bounce.e4", 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1);
      checkA("bounce.e5", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int e = 6; e <= 8; e++) begin
         applyStimulus(1);
         checkA($sformatf("bounce.e%0d", e), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      applyStimulus(1);
      checkA("bounce.e9", 1'b1, 1'b1, 1'b0, 1'b0);
      ifA.I = 1'b0;
      applyStimulus(8);
      checkA("bounce.back", 1'b0, 1'b0, 1'b0, 1'b0);

      // Glitch: three high samples only. BUSY is set after edges 2-4 and O never moves.
      $display("[TB] glitch");
      ifA.I = 1'b1;
      applyStimulus(3);
      ifA.I = 1'b0;
      applyStimulus(1);
      checkA("glitch.e3", 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1);
      checkA("glitch.e4", 1'b0, 1'b0, 1'b0, 1'b1);
      for (int e = 5; e <= 9; e++) begin
         applyStimulus(1);
         checkA($sformatf("glitch.e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Reset mid-count: asserting reset between edges 3 and 4 clears state at once.
      // After release with I still high, a full 6-edge acceptance is needed.
      $display("[TB] reset mid-count");
      ifA.I = 1'b1;
      applyStimulus(4);
      checkA("rstmid.e3", 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rstmid.cntBefore", {5'd0, dutA.cnt_q}, 8'd2);
      #2;
      rst = 1'b1;
      #1;
      checkA("rstmid.async", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rstmid.cnt", {5'd0, dutA.cnt_q}, 8'd0);
      #2;
      rst = 1'b0;
      for (int e = 0; e <= 4; e++) begin
         applyStimulus(1);
         checkOutput($sformatf("rstmid.e%0d.O", e), {7'd0, ifA.O}, 8'd0);
         checkOutput($sformatf("rstmid.e%0d.RISE", e), {7'd0, ifA.RISE}, 8'd0);
      end
      applyStimulus(1);
      checkA("rstmid.e5", 1'b1, 1'b1, 1'b0, 1'b0);

      // Single-cycle window: O/RISE after edge 2, BUSY never set.
      $display("[TB] DB_CYCLES=1");
      ifB.I = 1'b1;
      for (int e = 0; e <= 1; e++) begin
         applyStimulus(1);
         checkOutput($sformatf("db1.e%0d.O", e), {7'd0, ifB.O}, 8'd0);
         checkOutput($sformatf("db1.e%0d.BUSY", e), {7'd0, ifB.BUSY}, 8'd0);
      end
      applyStimulus(1);
      checkOutput("db1.e2.O", {7'd0, ifB.O}, 8'd1);
      checkOutput("db1.e2.RISE", {7'd0, ifB.RISE}, 8'd1);
      checkOutput("db1.e2.BUSY", {7'd0, ifB.BUSY}, 8'd0);
      applyStimulus(1);
      checkOutput("db1.e3.RISE", {7'd0, ifB.RISE}, 8'd0);
      checkOutput("db1.e3.O", {7'd0, ifB.O}, 8'd1);
      ifB.I = 1'b0;
      applyStimulus(2);
      checkOutput("db1.fall.e1.O", {7'd0, ifB.O}, 8'd1);
      applyStimulus(1);
      checkOutput("db1.fall.e2.O", {7'd0, ifB.O}, 8'd0);
      checkOutput("db1.fall.e2.FALL", {7'd0, ifB.FALL}, 8'd1);
      checkOutput("db1.fall.e2.BUSY", {7'd0, ifB.BUSY}, 8'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
